// File: rtl/xbar_out_sched_pkg.sv
// Shared types and helpers for the crossbar output scheduler.
package xbar_out_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    XFER = 2'd2
  } state_t;

  // LSB position of the select field, which occupies the top clog2(n_inputs)
  // bits of the control word.
  function automatic int sel_lsb(input int n_inputs, input int cw);
    return cw - $clog2(n_inputs);
  endfunction

endpackage

// File: rtl/xbar_out_sched_rr_pick.sv
// Cyclic first-set finder: the lowest index at or after rr_ptr (wrapping) whose
// req_val bit is set, plus a flag saying whether any bit was set at all.
module rr_pick #(
  parameter int N_INPUTS = 2,
  parameter int SEL_W    = $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0] req_val,
  input  logic [SEL_W-1:0]    rr_ptr,
  output logic [SEL_W-1:0]    idx,
  output logic                found
);

  localparam logic [SEL_W:0] N_VAL = (SEL_W+1)'(N_INPUTS);

  logic [N_INPUTS-1:0] rot;
  logic [SEL_W-1:0]    off;
  logic [SEL_W:0]      sum;

  // Rotate so rot[0] is input rr_ptr, take the nearest set offset, map it back.
  always_comb begin
    rot   = N_INPUTS'({req_val, req_val} >> rr_ptr);
    found = |rot;
    off   = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (rot[i]) off = i[SEL_W-1:0];
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    idx = (sum >= N_VAL) ? SEL_W'(sum - N_VAL) : sum[SEL_W-1:0];
  end

endmodule

// File: rtl/xbar_out_sched.sv
// Output-side scheduler for a one-output crossbar: round-robin picks an input,
// hands the crossbar a control word, then owns the output for up to MAX_BURST
// transfers or until the owner stops requesting.
//
// Handshake: the control word transfers on a cycle where control_val and
// control_rdy are both high; control_val stays high and control stays stable
// until that happens. fire marks one completed data transfer on the crossbar
// output (send_val & send_rdy) and is only meaningful while grant is non-zero.
module xbar_out_sched
  import xbar_out_sched_pkg::*;
#(
  parameter int N_INPUTS          = 2,
  parameter int CONTROL_BIT_WIDTH = 32,
  parameter int MAX_BURST         = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_INPUTS-1:0]                req_val,
  input  logic                               fire,
  output logic [CONTROL_BIT_WIDTH-1:0]       control,
  output logic                               control_val,
  input  logic                               control_rdy,
  output logic [N_INPUTS-1:0]                grant,
  output logic                               busy,
  output state_t                             dbg_state,
  output logic [$clog2(N_INPUTS)-1:0]        dbg_sel,
  output logic [$clog2(N_INPUTS)-1:0]        dbg_rr_ptr,
  output logic [$clog2(MAX_BURST+1)-1:0]     dbg_cnt
);

  localparam int                SEL_W    = $clog2(N_INPUTS);
  localparam int                CNT_W    = $clog2(MAX_BURST + 1);
  localparam int                SEL_LSB  = sel_lsb(N_INPUTS, CONTROL_BIT_WIDTH);
  localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(N_INPUTS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_BURST - 1);

  state_t           state, state_n;
  logic [SEL_W-1:0] sel, sel_n;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             rel;

  rr_pick #(
    .N_INPUTS (N_INPUTS),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .req_val (req_val),
    .rr_ptr  (rr_ptr),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  // State, owner, round-robin pointer and burst counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      sel    <= sel_n;
      rr_ptr <= rr_ptr_n;
      cnt    <= cnt_n;
    end
  end

  // Next-state logic: arbitrate in IDLE, wait for control acceptance in CFG,
  // count bursts and decide release in XFER.
  always_comb begin
    state_n  = state;
    sel_n    = sel;
    rr_ptr_n = rr_ptr;
    cnt_n    = cnt;
    rel      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          sel_n   = pick_idx;
          state_n = CFG;
        end
      end
      CFG: begin
        // fire and req_val are deliberately ignored until the crossbar is set up.
        if (control_rdy) begin
          state_n = XFER;
          cnt_n   = '0;
        end
      end
      XFER: begin
        if (fire) begin
          // The final transfer of a full burst releases without advancing cnt,
          // so cnt tops out at MAX_BURST-1.
          if (cnt == LAST_CNT) begin
            rel = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
            rel   = !req_val[sel];
          end
        end else begin
          rel = !req_val[sel];
        end
        if (rel) begin
          state_n  = IDLE;
          rr_ptr_n = (sel == LAST_IDX) ? '0 : sel + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from the registered state and owner only.
  always_comb begin
    control     = '0;
    control_val = 1'b0;
    grant       = '0;
    busy        = (state != IDLE);
    if (state == CFG) begin
      control[SEL_LSB +: SEL_W] = sel;
      control_val               = 1'b1;
    end
    if (state == XFER) grant[sel] = 1'b1;
  end

  assign dbg_state  = state;
  assign dbg_sel    = sel;
  assign dbg_rr_ptr = rr_ptr;
  assign dbg_cnt    = cnt;

endmodule

// File: doc/xbar_out_sched.md
XBAR_OUT_SCHED -- requirements
Module: xbar_out_sched

Interface
- REQ-001: Parameter N_INPUTS, default 2, number of crossbar inputs being arbitrated; legal values are 2 or more.
- REQ-002: Parameter CONTROL_BIT_WIDTH, default 32, width of the control word sent to the one-output crossbar.
- REQ-003: Parameter MAX_BURST, default 4, maximum number of transfers per grant; legal values are 1 or more.
- REQ-004: Port clk, input, width 1, the single clock; all state changes on its rising edge.
- REQ-005: Port reset, input, width 1, asynchronous active-low reset (0 = in reset).
- REQ-006: Port req_val, input, width N_INPUTS, copy of each crossbar input's recv_val; bit i means input i has a message pending.
- REQ-007: Port fire, input, width 1, crossbar output transfer event (send_val AND send_rdy) in this cycle.
- REQ-008: Port control, output, width CONTROL_BIT_WIDTH, selection word for the crossbar.
- REQ-009: Port control_val, output, width 1, control word is valid.
- REQ-010: Port control_rdy, input, width 1, crossbar accepts the control word.
- REQ-011: Port grant, output, width N_INPUTS, one-hot current owner; all zero when there is no owner.
- REQ-012: Port busy, output, width 1, high in CFG and XFER states.

Function
- REQ-013: The block SHALL implement a three-state FSM with states IDLE, CFG and XFER; all outputs SHALL be registered or decoded from state only.
- REQ-014: IDLE: if any req_val bit is 1, the block SHALL pick the first set bit at or after rr_ptr, searching cyclically upward; sel SHALL take that index, and the next state SHALL be CFG.
- REQ-015: IDLE with req_val all zero SHALL stay in IDLE with no change to sel or rr_ptr.
- REQ-016: Control word: bits [CW-1 : CW-clog2(N_INPUTS)] SHALL equal sel; all lower bits SHALL be 0; control SHALL be 0 outside CFG.
- REQ-017: CFG: control_val SHALL be 1. When control_val AND control_rdy, the next state SHALL be XFER and cnt SHALL be set to 0. Otherwise the block SHALL hold CFG and keep control stable.
- REQ-018: In CFG, fire events SHALL be ignored, and a drop of req_val[sel] SHALL NOT abort the configuration.
- REQ-019: XFER: grant[sel] SHALL be 1. Each fire SHALL increment cnt, which is clog2(MAX_BURST+1) bits wide.
- REQ-020: XFER release, case 1: fire while cnt equals MAX_BURST-1 SHALL release the grant.
- REQ-021: XFER release, case 2: req_val[sel] equal to 0 in a cycle without fire SHALL release the grant.
- REQ-022: XFER release, case 3: fire and req_val[sel] falling in the same cycle SHALL count the transfer, then release the grant.
- REQ-023: On any release, the next state SHALL be IDLE and rr_ptr SHALL become (sel+1) mod N_INPUTS.
- REQ-024: Latency: a request sampled in IDLE at edge t SHALL produce control_val=1 after edge t. The minimum gap from release to the next control_val is 2 cycles (IDLE, then CFG).
- REQ-025: cnt SHALL never exceed MAX_BURST-1 and SHALL NOT wrap.
- REQ-026: rr_ptr SHALL wrap from N_INPUTS-1 to 0.

Reset
- REQ-027: While reset=0 the block SHALL asynchronously force state=IDLE, rr_ptr=0, sel=0 and cnt=0, and drive control=0, control_val=0, grant=0 and busy=0.
- REQ-028: An assertion of reset mid-CFG or mid-XFER SHALL take effect immediately, without waiting for a clock edge.
- REQ-029: Reset deassertion SHALL be sampled synchronously, and the first arbitration SHALL occur at the first rising edge after reset goes to 1.

Structure
- REQ-030: A shared package SHALL hold the FSM state enum (IDLE, CFG, XFER) and a helper that computes the select-field position from N_INPUTS and CONTROL_BIT_WIDTH.
- REQ-031: One sub-module, rr_pick, SHALL be combinational and SHALL return a cyclic first-set index with a found flag, given req_val and rr_ptr. All other logic SHALL be inline.

Verification
- REQ-032: Scenario, basic grant: N=2, MAX_BURST=4, req_val=2'b10 held, control_rdy=1. Required: control=0x8000_0000 with control_val for 1 cycle; then grant=2'b10; after 4 fires, IDLE and rr_ptr=0.
- REQ-033: Scenario, round-robin: N=4, req_val=4'b1111 held, fire every XFER cycle. Required: grants in order 0,1,2,3,0; each grant lasts exactly MAX_BURST fires.
- REQ-034: Scenario, early release: N=2, owner 0, req_val[0] drops after 2 fires with no fire in the drop cycle. Required: IDLE next cycle, cnt stops at 2, rr_ptr=1.
- REQ-035: Scenario, stalled config: control_rdy=0 for 5 cycles, then 1. Required: control_val held 6 cycles with control stable; fires during CFG are not counted.
- REQ-036: Scenario, simultaneous fire and drop: fire=1 and req_val[sel]=0 in the same cycle with cnt=1. Required: cnt becomes 2, the grant is released, and the state is IDLE.
- REQ-037: Scenario, asynchronous reset: reset=0 pulsed mid-XFER between clock edges. Required: grant=0, busy=0 and control_val=0 with no clock edge; after release, arbitration restarts from input 0.
